// File: rtl/ser.sv
// 8N1 serial byte transceiver: independent receive and transmit FSMs sharing one clock.
// Receive input is double-synchronised; all outputs are registered.
module ser #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic       txd,
    input  logic       start_xmt,
    input  logic [7:0] tx_data,
    output logic [7:0] char_in,
    output logic       rcv_done,
    output logic       xmt_done,
    output logic       frame_err,
    output logic       tx_busy
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_t;

    logic        rx_meta_q, rxs_q;
    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_brk_q, rx_brk_d;
    logic [7:0]  char_in_q, char_in_d;
    logic        rcv_done_q, rcv_done_d;
    logic        frame_err_q, frame_err_d;

    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;
    logic        xmt_done_q, xmt_done_d;
    logic        tx_busy_q, tx_busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_brk_q    <= 1'b0;
            char_in_q   <= '0;
            rcv_done_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rxd;
            rxs_q       <= rx_meta_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_brk_q    <= rx_brk_d;
            char_in_q   <= char_in_d;
            rcv_done_q  <= rcv_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_brk_d    = rx_brk_q;
        char_in_d   = char_in_q;
        rcv_done_d  = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rxs_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxs_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxs_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_STOP: begin
                // After a framing error, park here until the line goes idle so a break cannot restart reception.
                if (rx_brk_q) begin
                    if (rxs_q) begin
                        rx_brk_d   = 1'b0;
                        rx_state_d = RX_IDLE;
                    end
                end else if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rxs_q) begin
                        char_in_d  = rx_shift_q;
                        rcv_done_d = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        rx_brk_d    = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            xmt_done_q <= 1'b0;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            xmt_done_q <= xmt_done_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    // Line outputs are registered from the current state, so txd lags the state by one cycle.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = 1'b1;
        xmt_done_d = (tx_state_q == TX_DONE);
        tx_busy_d  = (tx_state_q != TX_IDLE);
        case (tx_state_q)
            TX_IDLE: begin
                if (start_xmt) begin
                    tx_shift_d = tx_data;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                txd_d = 1'b0;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TX_DATA: begin
                txd_d = tx_shift_q[0];
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DONE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TX_DONE: begin
                if (!start_xmt) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign txd       = txd_q;
    assign char_in   = char_in_q;
    assign rcv_done  = rcv_done_q;
    assign xmt_done  = xmt_done_q;
    assign frame_err = frame_err_q;
    assign tx_busy   = tx_busy_q;

endmodule

// File: tb/tb_ser.sv
// Scoreboard bench for ser: expected bytes are queued at stimulus time and
// popped by independent RX/TX monitors; TX is decoded from the line at bit centres.
module tb_ser;
    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd_drv = 1'b1;
    logic       loopback = 1'b0;
    logic       rxd, txd, start_xmt = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] char_in;
    logic       rcv_done, xmt_done, frame_err, tx_busy;

    assign rxd = loopback ? txd : rxd_drv;
    always #5 clk = ~clk;

    ser #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .txd(txd), .start_xmt(start_xmt),
        .tx_data(tx_data), .char_in(char_in), .rcv_done(rcv_done),
        .xmt_done(xmt_done), .frame_err(frame_err), .tx_busy(tx_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    int rcv_cnt = 0, ferr_cnt = 0, rx_pushed = 0, ferr_exp = 0, last_rcv_cyc = 0;

    always @(negedge clk) begin
        if (rst_n && rcv_done) begin
            rcv_cnt++;
            last_rcv_cyc = cyc;
            if (rx_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected actual=%0h required=none", char_in);
            end else begin
                check("rx_byte", {24'd0, char_in}, {24'd0, rx_exp.pop_front()});
            end
        end
        if (rst_n && frame_err) ferr_cnt++;
    end

    bit         tm_act = 1'b0;
    int         tm_cnt = 0;
    logic [7:0] tm_byte = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            tm_act = 1'b0;
        end else if (!tm_act) begin
            if (txd == 1'b0) begin
                tm_act = 1'b1;
                tm_cnt = 0;
            end
        end else begin
            tm_cnt++;
            if (tm_cnt == C / 2) check("tx_start_mid", {31'd0, txd}, 32'd0);
            if (tm_cnt > C / 2 && tm_cnt < C / 2 + 9 * C && ((tm_cnt - C / 2) % C) == 0)
                tm_byte[(tm_cnt - C / 2) / C - 1] = txd;
            if (tm_cnt == C / 2 + 9 * C) begin
                check("tx_stop_mid", {31'd0, txd}, 32'd1);
                if (tx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected actual=%0h required=none", tm_byte);
                end else begin
                    check("tx_byte", {24'd0, tm_byte}, {24'd0, tx_exp.pop_front()});
                end
                tm_act = 1'b0;
            end
        end
    end

    task automatic send_rx(input logic [7:0] b, input logic stop_b);
        logic [9:0] fr;
        fr = {stop_b, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd_drv = fr[i];
            repeat (C) @(negedge clk);
        end
    endtask

    task automatic rx_good(input logic [7:0] b);
        rx_exp.push_back(b);
        rx_pushed++;
        send_rx(b, 1'b1);
    endtask

    task automatic tx_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        tx_data = b;
        start_xmt = 1'b1;
        tx_exp.push_back(b);
        n = 0;
        while (!xmt_done && n < 400) begin @(negedge clk); n++; end
        check("tx_done_seen", {31'd0, xmt_done}, 32'd1);
        start_xmt = 1'b0;
        tx_data = 8'($urandom);
        n = 0;
        while (xmt_done && n < 10) begin @(negedge clk); n++; end
        check("tx_done_drop", {31'd0, xmt_done}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_txd"}, {31'd0, txd}, 32'd1);
        check({tag, "_char_in"}, {24'd0, char_in}, 32'd0);
        check({tag, "_rcv_done"}, {31'd0, rcv_done}, 32'd0);
        check({tag, "_xmt_done"}, {31'd0, xmt_done}, 32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_tx_busy"}, {31'd0, tx_busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, base, k, rise, lat;
        logic [9:0] fr;
        string s;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame with latency measurement
        base = rcv_cnt;
        t0 = cyc;
        rx_good(8'h41);
        repeat (5) @(negedge clk);
        check("rx41_count", rcv_cnt - base, 1);
        check("rx41_char", {24'd0, char_in}, 32'h41);
        check("rx41_no_ferr", ferr_cnt, 0);
        lat = last_rcv_cyc - t0;
        checks++;
        if (lat < 153 || lat > 155) begin
            errors++;
            $display("FAIL rx_latency actual=%0d required=153..155", lat);
        end

        // Back-to-back frames, no idle gap
        base = rcv_cnt;
        s = "HELLO WRLD";
        for (int i = 0; i < s.len(); i++) rx_good(s[i]);
        rx_good(8'h0D);
        repeat (5) @(negedge clk);
        check("b2b_count", rcv_cnt - base, 11);
        check("b2b_last", {24'd0, char_in}, 32'h0D);

        // Framing error then break
        base = rcv_cnt;
        send_rx(8'h55, 1'b0);
        ferr_exp++;
        rxd_drv = 1'b0;
        repeat (40) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (20) @(negedge clk);
        check("ferr_count", ferr_cnt, ferr_exp);
        check("ferr_no_rcv", rcv_cnt - base, 0);
        check("ferr_char_kept", {24'd0, char_in}, 32'h0D);
        rx_good(8'hA5);
        repeat (5) @(negedge clk);
        check("after_break_char", {24'd0, char_in}, 32'hA5);

        // Short glitch on the line
        base = rcv_cnt;
        rxd_drv = 1'b0;
        repeat (3) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_rcv", rcv_cnt - base, 0);
        check("glitch_no_ferr", ferr_cnt, ferr_exp);
        rx_good(8'h3C);
        repeat (5) @(negedge clk);
        check("after_glitch_char", {24'd0, char_in}, 32'h3C);

        // Directed transmit of 8'hC3 with held request
        @(negedge clk);
        tx_data = 8'hC3;
        start_xmt = 1'b1;
        tx_exp.push_back(8'hC3);
        fr = {1'b1, 8'hC3, 1'b0};
        k = cyc + 1;
        rise = -1;
        for (int n = 0; n < 260; n++) begin
            @(negedge clk);
            if (cyc == k) tx_data = 8'hFF;
            if (cyc == k) check("txd_before_fall", {31'd0, txd}, 32'd1);
            if (cyc == k + 1) begin
                check("txd_fall", {31'd0, txd}, 32'd0);
                check("busy_rise", {31'd0, tx_busy}, 32'd1);
            end
            for (int j = 0; j < 10; j++)
                if (cyc == k + 1 + j * C + C / 2) check("tx_c3_bit", {31'd0, txd}, {31'd0, fr[j]});
            if (xmt_done && rise < 0) rise = cyc;
            if (rise >= 0 && cyc == rise + 20) break;
        end
        check("xmt_done_rise", rise, k + 161);
        check("held_txd_idle", {31'd0, txd}, 32'd1);
        check("held_xmt_done", {31'd0, xmt_done}, 32'd1);
        start_xmt = 1'b0;
        @(negedge clk);
        check("xmt_done_hold1", {31'd0, xmt_done}, 32'd1);
        @(negedge clk);
        check("xmt_done_fall", {31'd0, xmt_done}, 32'd0);
        check("busy_fall", {31'd0, tx_busy}, 32'd0);

        // Concurrent random RX and TX traffic
        fork
            for (int i = 0; i < 5; i++) rx_good(8'($urandom));
            for (int i = 0; i < 5; i++) tx_byte(8'($urandom));
        join
        repeat (30) @(negedge clk);
        check("rand_rx_drained", rx_exp.size(), 0);
        check("rand_tx_drained", tx_exp.size(), 0);

        // Reset in the middle of both frames
        fork
            send_rx(8'h33, 1'b1);
            begin
                tx_data = 8'h5A;
                start_xmt = 1'b1;
            end
            begin
                repeat (80) @(negedge clk);
                rst_n = 1'b0;
                start_xmt = 1'b0;
                #1;
                check_reset_outputs("midrst");
                repeat (120) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        check("post_rst_char", {24'd0, char_in}, 32'd0);
        check("post_rst_busy", {31'd0, tx_busy}, 32'd0);

        // Loopback
        loopback = 1'b1;
        base = rcv_cnt;
        rx_exp.push_back(8'h7E);
        rx_pushed++;
        tx_byte(8'h7E);
        repeat (20) @(negedge clk);
        check("loop_char", {24'd0, char_in}, 32'h7E);
        check("loop_count", rcv_cnt - base, 1);
        loopback = 1'b0;

        repeat (50) @(negedge clk);
        check("final_rx_queue", rx_exp.size(), 0);
        check("final_tx_queue", tx_exp.size(), 0);
        check("final_rcv_total", rcv_cnt, rx_pushed);
        check("final_ferr_total", ferr_cnt, ferr_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
